// File: rtl/key_event_bank_if.sv
// Pin-side bundle for key_event_bank: raw key levels and event gate in,
// debounced level and single-cycle event pulses out.
interface key_event_bank_if #(
  parameter int N_KEYS = 4
);
  logic              i_en;
  logic [N_KEYS-1:0] i_keys;
  logic [N_KEYS-1:0] o_level;
  logic [N_KEYS-1:0] o_press;
  logic [N_KEYS-1:0] o_release;
  logic [N_KEYS-1:0] o_long;
  logic [N_KEYS-1:0] o_repeat;

  modport master (
    output i_en, i_keys,
    input  o_level, o_press, o_release, o_long, o_repeat
  );

  modport slave (
    input  i_en, i_keys,
    output o_level, o_press, o_release, o_long, o_repeat
  );
endinterface

// File: rtl/key_event_bank.sv
// N-channel push-button conditioner: per-key sync, debounce, and a hold FSM
// producing press / release / long / auto-repeat pulses.
module key_event_lane #(
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000,
  parameter int CNT_W         = 24
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_en,
  input  logic i_key,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);
  localparam logic [CNT_W-1:0] DEB_TC  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, HELD, RPT} state_t;

  logic             s1, s2, stable;
  logic [CNT_W-1:0] deb_cnt, hold_cnt, hold_nx;
  logic             mismatch, deb_done, rise, fall;
  logic             press_d, release_d, long_d, repeat_d;
  state_t           state, state_nx;

  assign mismatch = s2 ^ stable;
  assign deb_done = mismatch && (deb_cnt == DEB_TC);
  // rise/fall mark the edge on which stable itself toggles, so events line up with o_level
  assign rise     = deb_done & ~stable;
  assign fall     = deb_done & stable;
  assign o_level  = stable;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      stable  <= 1'b0;
      deb_cnt <= '0;
    end else begin
      s1 <= i_key ^ ACTIVE_LOW;
      s2 <= s1;
      if (!mismatch) begin
        deb_cnt <= '0;
      end else if (deb_done) begin
        deb_cnt <= '0;
        stable  <= ~stable;
      end else begin
        deb_cnt <= deb_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (rise) state_nx = HELD;
      HELD:    if (fall) state_nx = IDLE;
               else if (hold_cnt == LONG_TC) state_nx = RPT;
      RPT:     if (fall) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    hold_nx   = '0;
    case (state)
      IDLE: press_d = rise;
      HELD: begin
        if (fall)                       release_d = 1'b1;
        else if (hold_cnt == LONG_TC)   long_d    = 1'b1;
        else                            hold_nx   = hold_cnt + 1'b1;
      end
      RPT: begin
        // with repeat disabled the counter parks at 0 instead of free-running
        if (fall)                       release_d = 1'b1;
        else if (REPEAT_CYCLES == 0)    hold_nx   = '0;
        else if (hold_cnt == REP_TC)    repeat_d  = 1'b1;
        else                            hold_nx   = hold_cnt + 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hold_cnt  <= '0;
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_long    <= 1'b0;
      o_repeat  <= 1'b0;
    end else begin
      hold_cnt  <= hold_nx;
      o_press   <= press_d   & i_en;
      o_release <= release_d & i_en;
      o_long    <= long_d    & i_en;
      o_repeat  <= repeat_d  & i_en;
    end
  end
endmodule

module key_event_bank #(
  parameter int N_KEYS        = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int DEB_CYCLES    = 120000,
  parameter int LONG_CYCLES   = 6000000,
  parameter int REPEAT_CYCLES = 1200000
) (
  input logic            i_clk,
  input logic            i_rst,
  key_event_bank_if.slave bus
);
  localparam int MAX_DL = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
  localparam int MAX_C  = (MAX_DL > REPEAT_CYCLES) ? MAX_DL : REPEAT_CYCLES;
  localparam int CNT_W  = $clog2(MAX_C) + 1;

  logic [N_KEYS-1:0] level, press, rel, lng, rpt;

  for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
    key_event_lane #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_lane (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_en     (bus.i_en),
      .i_key    (bus.i_keys[g]),
      .o_level  (level[g]),
      .o_press  (press[g]),
      .o_release(rel[g]),
      .o_long   (lng[g]),
      .o_repeat (rpt[g])
    );
  end

  assign bus.o_level   = level;
  assign bus.o_press   = press;
  assign bus.o_release = rel;
  assign bus.o_long    = lng;
  assign bus.o_repeat  = rpt;
endmodule
